// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator BIST engine.
package comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned ERR_W = 8;

endpackage

// File: rtl/comparator_bist_if.sv
// Operand/result bus between the BIST engine and the comparator under test.
interface comparator_bist_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             less;
    logic             great;
    logic             eq;

    modport master (output a, output b, input less, input great, input eq);
    modport slave  (input a, input b, output less, output great, output eq);
endinterface

// File: rtl/comparator_ref.sv
// Golden unsigned magnitude comparator.
module comparator_ref #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             exp_less,
    output logic             exp_great,
    output logic             exp_eq
);

    // Reference relations of the two operands.
    always_comb begin
        exp_less  = (a < b);
        exp_great = (a > b);
        exp_eq    = (a == b);
    end

endmodule

// File: rtl/comparator_bist.sv
// Exhaustive self-test engine for a magnitude comparator.
module comparator_bist
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    comparator_bist_if.master cmp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              fail_valid,
    output logic [WIDTH-1:0]  fail_a,
    output logic [WIDTH-1:0]  fail_b
);

    localparam int unsigned IDX_W = 2 * WIDTH;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             exp_less;
    logic             exp_great;
    logic             exp_eq;
    logic             mismatch;

    // Operands come straight from the index register, so they are registered
    // and hold the last vector in DONE.
    assign cmp.a = idx[IDX_W-1:WIDTH];
    assign cmp.b = idx[WIDTH-1:0];

    comparator_ref #(.WIDTH(WIDTH)) u_ref (
        .a         (cmp.a),
        .b         (cmp.b),
        .exp_less  (exp_less),
        .exp_great (exp_great),
        .exp_eq    (exp_eq)
    );

    // Any differing flag, including all-zero or multi-hot, is a mismatch.
    always_comb begin
        mismatch = (cmp.less != exp_less) | (cmp.great != exp_great) | (cmp.eq != exp_eq);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode; start is honoured only when not running.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start) state_next = ST_SETTLE;
            ST_SETTLE:        if (cnt == '0) state_next = ST_CHECK;
            ST_CHECK:         state_next = (idx == '1) ? ST_DONE : ST_SETTLE;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state and error counter.
    always_comb begin
        busy = (state == ST_SETTLE) || (state == ST_CHECK);
        done = (state == ST_DONE);
        pass = (state == ST_DONE) && (err_count == '0);
    end

    // Index, settle counter, saturating error counter and first-fail capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            cnt        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx        <= '0;
                        cnt        <= CNT_LOAD;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + ERR_W'(1);
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_a     <= cmp.a;
                            fail_b     <= cmp.b;
                        end
                    end
                    if (idx != '1) begin
                        idx <= idx + IDX_W'(1);
                        cnt <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_bist.sv
// Directed bench: two BIST instances (1-bit/settle 2 and 4-bit/settle 1)
// against behavioural comparators with selectable faults.
module tb_comparator_bist;
    import comparator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    int   mode1 = 0;   // 0 correct, 1 eq tied 0, 2 less/great swapped

    int vectors = 0;
    int miscompares = 0;
    int n;

    logic             busy1, done1, pass1, fv1;
    logic [ERR_W-1:0] err1;
    logic [0:0]       fa1, fb1;
    logic             busy2, done2, pass2, fv2;
    logic [ERR_W-1:0] err2;
    logic [3:0]       fa2, fb2;

    comparator_bist_if #(.WIDTH(1)) if1 ();
    comparator_bist_if #(.WIDTH(4)) if2 ();

    always #5 clk = ~clk;

    // Comparator under test for instance 1, with fault injection.
    always_comb begin
        if1.less  = (if1.a < if1.b);
        if1.great = (if1.a > if1.b);
        if1.eq    = (if1.a == if1.b);
        if (mode1 == 1) if1.eq = 1'b0;
        if (mode1 == 2) begin
            if1.less  = (if1.a > if1.b);
            if1.great = (if1.a < if1.b);
        end
    end

    // Comparator for instance 2: every output stuck high.
    assign if2.less  = 1'b1;
    assign if2.great = 1'b1;
    assign if2.eq    = 1'b1;

    comparator_bist #(.WIDTH(1), .SETTLE(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .cmp(if1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
    );

    comparator_bist #(.WIDTH(4), .SETTLE(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .cmp(if2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int which);
        if (which == 1) start1 = 1'b1;
        else            start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int limit, output int cycles);
        cycles = 0;
        while (((which == 1) ? done1 : done2) == 1'b0 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic check_reset1(input string tag);
        check({tag, "_a"}, 32'(if1.a), 0);
        check({tag, "_b"}, 32'(if1.b), 0);
        check({tag, "_busy"}, 32'(busy1), 0);
        check({tag, "_done"}, 32'(done1), 0);
        check({tag, "_pass"}, 32'(pass1), 0);
        check({tag, "_err"}, 32'(err1), 0);
        check({tag, "_fv"}, 32'(fv1), 0);
        check({tag, "_fa"}, 32'(fa1), 0);
        check({tag, "_fb"}, 32'(fb1), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset1("rst");
        check("rst_busy2", 32'(busy2), 0);
        check("rst_err2", 32'(err2), 0);

        // Run 1: correct comparator, start re-pulsed mid-run must be ignored.
        mode1 = 0;
        pulse_start(1);
        for (int k = 0; k < 12; k++) begin
            check("trace_a", 32'(if1.a), 32'((k / 3) >> 1));
            check("trace_b", 32'(if1.b), 32'((k / 3) & 1));
            check("trace_busy", 32'(busy1), 1);
            check("trace_done", 32'(done1), 0);
            if (k == 5) start1 = 1'b1;
            if (k == 6) start1 = 1'b0;
            @(negedge clk);
        end
        check("r1_done", 32'(done1), 1);
        check("r1_busy", 32'(busy1), 0);
        check("r1_pass", 32'(pass1), 1);
        check("r1_err", 32'(err1), 0);
        check("r1_fv", 32'(fv1), 0);
        check("r1_a_hold", 32'(if1.a), 1);
        check("r1_b_hold", 32'(if1.b), 1);

        // Run 2: eq stuck at 0, restart from DONE.
        mode1 = 1;
        pulse_start(1);
        check("r2_done_clr", 32'(done1), 0);
        check("r2_busy", 32'(busy1), 1);
        wait_done(1, 40, n);
        check("r2_len", 32'(n), 12);
        check("r2_err", 32'(err1), 2);
        check("r2_fv", 32'(fv1), 1);
        check("r2_fa", 32'(fa1), 0);
        check("r2_fb", 32'(fb1), 0);
        check("r2_pass", 32'(pass1), 0);

        // Run 3: less/great swapped.
        mode1 = 2;
        pulse_start(1);
        wait_done(1, 40, n);
        check("r3_len", 32'(n), 12);
        check("r3_err", 32'(err1), 2);
        check("r3_fv", 32'(fv1), 1);
        check("r3_fa", 32'(fa1), 0);
        check("r3_fb", 32'(fb1), 1);
        check("r3_pass", 32'(pass1), 0);

        // Run 4: correct comparator again, prior failure state must clear.
        mode1 = 0;
        pulse_start(1);
        check("r4_err_clr", 32'(err1), 0);
        check("r4_fv_clr", 32'(fv1), 0);
        wait_done(1, 40, n);
        check("r4_len", 32'(n), 12);
        check("r4_err", 32'(err1), 0);
        check("r4_pass", 32'(pass1), 1);

        // Run 5: eq fault, asynchronous reset while on vector 2 in SETTLE.
        mode1 = 1;
        pulse_start(1);
        repeat (6) @(negedge clk);
        check("r5_a_pre", 32'(if1.a), 1);
        check("r5_b_pre", 32'(if1.b), 0);
        check("r5_err_pre", 32'(err1), 1);
        check("r5_fv_pre", 32'(fv1), 1);
        rst = 1'b1;
        #1;
        check_reset1("midrst");
        @(negedge clk);
        rst = 1'b0;

        // Run 6: after reset, correct comparator passes.
        mode1 = 0;
        pulse_start(1);
        wait_done(1, 40, n);
        check("r6_len", 32'(n), 12);
        check("r6_pass", 32'(pass1), 1);
        check("r6_err", 32'(err1), 0);

        // Instance 2: 256 mismatches saturate the counter at 255.
        pulse_start(2);
        check("w4_busy", 32'(busy2), 1);
        wait_done(2, 700, n);
        check("w4_len", 32'(n), 512);
        check("w4_err", 32'(err2), 255);
        check("w4_fv", 32'(fv2), 1);
        check("w4_fa", 32'(fa2), 0);
        check("w4_fb", 32'(fb2), 0);
        check("w4_pass", 32'(pass2), 0);
        check("w4_busy_end", 32'(busy2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
